// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the LC-3b memory-stage controller.
package mem_stage_ctrl_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [3:0]  lc3b_mem_cs;

  // Bit positions inside the memory-stage control nibble
  localparam int CS_MEM_RD   = 0;
  localparam int CS_MEM_WR   = 1;
  localparam int CS_BYTE     = 2;
  localparam int CS_INDIRECT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } lc3b_memstate_t;

  // Memory is word-addressed on the bus; the byte lane is chosen separately
  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_align.sv
// Byte-lane steering: write mask, store-data replication, load extract/sign-extend.
module mem_byte_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic          addr_lsb,
  input  logic          is_byte,
  input  lc3b_word      store_data,
  input  lc3b_word      read_data,
  output lc3b_mem_wmask byte_enable,
  output lc3b_word      wdata,
  output lc3b_word      load_value
);

  // Word accesses pass straight through; byte accesses pick the lane from addr_lsb
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_data;
    load_value  = read_data;
    if (is_byte) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      wdata       = {store_data[7:0], store_data[7:0]};
      load_value  = addr_lsb ? {{8{read_data[15]}}, read_data[15:8]}
                             : {{8{read_data[7]}},  read_data[7:0]};
    end
  end

endmodule

// File: rtl/register.sv
// Generic loadable register with asynchronous active-high clear.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is asserted, clear on reset
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs the data-memory handshake for word/byte and
// indirect loads/stores, stalls upstream until done, returns aligned load data.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  lc3b_word      sr_address,
  input  lc3b_word      sr_data,
  input  lc3b_mem_cs    sr_cs,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      load_data,
  output logic          stall,
  output logic          done
);

  lc3b_memstate_t state, next_state;

  logic          req, is_rd, is_wr, is_byte, is_ind;
  logic          ptr_load, load_capture;
  lc3b_word      pointer, target;
  lc3b_mem_wmask align_be;
  lc3b_word      align_wdata, align_load;

  // Read wins when both request bits are set
  assign is_rd   = sr_cs[CS_MEM_RD];
  assign is_wr   = sr_cs[CS_MEM_WR] & ~sr_cs[CS_MEM_RD];
  assign req     = sr_cs[CS_MEM_RD] | sr_cs[CS_MEM_WR];
  assign is_byte = sr_cs[CS_BYTE];
  assign is_ind  = sr_cs[CS_INDIRECT];
  assign target  = is_ind ? pointer : sr_address;

  // Pointer fetched by the first access of an indirect operation
  register #(.WIDTH(16)) pointer_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ptr_load),
    .d     (mem_rdata),
    .q     (pointer)
  );

  mem_byte_align u_align (
    .addr_lsb    (target[0]),
    .is_byte     (is_byte),
    .store_data  (sr_data),
    .read_data   (mem_rdata),
    .byte_enable (align_be),
    .wdata       (align_wdata),
    .load_value  (align_load)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Load result register; holds until the next completed read
  // NOTE: load_data is cleared on reset because writeback may observe it before any load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      load_data <= '0;
    else if (load_capture)
      load_data <= align_load;
  end

  // Next-state and memory-port outputs, decoded from state
  always_comb begin
    next_state      = state;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    stall           = 1'b0;
    done            = 1'b0;
    ptr_load        = 1'b0;
    load_capture    = 1'b0;
    unique case (state)
      IDLE: begin
        // Stall in the same cycle the request appears; silent while reset holds
        stall = req & ~reset;
        if (req)
          next_state = is_ind ? IND : ACC;
      end
      IND: begin
        mem_read    = 1'b1;
        mem_address = word_align(sr_address);
        stall       = 1'b1;
        ptr_load    = mem_resp;
        if (mem_resp)
          next_state = ACC;
      end
      ACC: begin
        mem_address  = word_align(target);
        stall        = 1'b1;
        load_capture = mem_resp & is_rd;
        if (is_rd) begin
          mem_read = 1'b1;
        end else if (is_wr) begin
          mem_write       = 1'b1;
          mem_byte_enable = align_be;
          mem_wdata       = align_wdata;
        end
        if (mem_resp)
          next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] sr_address;
  logic [15:0] sr_data;
  logic [3:0]  sr_cs;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] load_data;
  logic        stall;
  logic        done;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .sr_address      (sr_address),
    .sr_data         (sr_data),
    .sr_cs           (sr_cs),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .load_data       (load_data),
    .stall           (stall),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mem_byte_enable !== 2'b00) begin errors++; $display("FAIL reset_be got %b exp 00", mem_byte_enable); end
    checks++; if (load_data !== 16'h0000) begin errors++; $display("FAIL reset_load_data got %h exp 0000", load_data); end
    checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_address); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h exp 0000", mem_wdata); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    int stall_cnt;
    sr_address = 16'h3001; sr_data = 16'h0000; sr_cs = 4'b0001; mem_resp = 1'b0;
    #1;
    stall_cnt = int'(stall);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wl_t0_read got %b exp 0", mem_read); end
    step();
    #1;
    stall_cnt += int'(stall);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL wl_acc_read got %b exp 1", mem_read); end
    checks++; if (mem_address !== 16'h3000) begin errors++; $display("FAIL wl_addr got %h exp 3000", mem_address); end
    step();
    #1;
    stall_cnt += int'(stall);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL wl_wait_read got %b exp 1", mem_read); end
    step();
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    stall_cnt += int'(stall);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL wl_resp_read got %b exp 1", mem_read); end
    step();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wl_done got %b exp 1", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wl_done_stall got %b exp 0", stall); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wl_done_read got %b exp 0", mem_read); end
    checks++; if (load_data !== 16'hBEEF) begin errors++; $display("FAIL wl_load_data got %h exp beef", load_data); end
    checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL wl_stall_cycles got %0d exp 4", stall_cnt); end
    sr_cs = 4'b0000;
    step();
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wl_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_byte_load(input logic [15:0] addr, input logic [15:0] exp_addr, input logic [15:0] exp_data);
    sr_address = addr; sr_cs = 4'b0101; mem_resp = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bl_t0_stall got %b exp 1", stall); end
    step();
    mem_resp = 1'b1; mem_rdata = 16'h80FF;
    #1;
    checks++; if (mem_address !== exp_addr) begin errors++; $display("FAIL bl_addr got %h exp %h", mem_address, exp_addr); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL bl_read got %b exp 1", mem_read); end
    step();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bl_done got %b exp 1", done); end
    checks++; if (load_data !== exp_data) begin errors++; $display("FAIL bl_load_data got %h exp %h", load_data, exp_data); end
    sr_cs = 4'b0000;
    step();
  endtask

  task automatic test_byte_store();
    sr_address = 16'h2003; sr_data = 16'h00A5; sr_cs = 4'b0110; mem_resp = 1'b0;
    step();
    #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL bs_write got %b exp 1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL bs_read got %b exp 0", mem_read); end
    checks++; if (mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL bs_wdata got %h exp a5a5", mem_wdata); end
    checks++; if (mem_byte_enable !== 2'b10) begin errors++; $display("FAIL bs_be got %b exp 10", mem_byte_enable); end
    checks++; if (mem_address !== 16'h2002) begin errors++; $display("FAIL bs_addr got %h exp 2002", mem_address); end
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL bs_write_held got %b exp 1 wait %0d", mem_write, i); end
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bs_done got %b exp 1", done); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL bs_write_drop got %b exp 0", mem_write); end
    checks++; if (load_data !== 16'hFFFF) begin errors++; $display("FAIL bs_load_hold got %h exp ffff", load_data); end
    sr_cs = 4'b0000;
    step();
  endtask

  task automatic test_indirect_store();
    sr_address = 16'h4000; sr_data = 16'h1234; sr_cs = 4'b1010;
    // Stray response while still IDLE must not advance the IND phase
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL is_t0_stall got %b exp 1", stall); end
    step();
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL is_ind_read got %b exp 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL is_ind_write got %b exp 0", mem_write); end
    checks++; if (mem_address !== 16'h4000) begin errors++; $display("FAIL is_ind_addr got %h exp 4000", mem_address); end
    step();
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL is_ind_held got %b exp 1", mem_read); end
    mem_resp = 1'b1; mem_rdata = 16'h5002;
    step();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL is_acc_write got %b exp 1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL is_acc_read got %b exp 0", mem_read); end
    checks++; if (mem_address !== 16'h5002) begin errors++; $display("FAIL is_acc_addr got %h exp 5002", mem_address); end
    checks++; if (mem_byte_enable !== 2'b11) begin errors++; $display("FAIL is_acc_be got %b exp 11", mem_byte_enable); end
    checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL is_acc_wdata got %h exp 1234", mem_wdata); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL is_acc_stall got %b exp 1", stall); end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL is_done got %b exp 1", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL is_done_stall got %b exp 0", stall); end
    sr_cs = 4'b0000;
    step();
  endtask

  task automatic test_rd_priority();
    sr_address = 16'h0010; sr_data = 16'h7777; sr_cs = 4'b0011; mem_resp = 1'b0;
    step();
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL pri_read got %b exp 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL pri_write got %b exp 0", mem_write); end
    mem_resp = 1'b1; mem_rdata = 16'h0042;
    step();
    mem_resp = 1'b0;
    #1;
    checks++; if (load_data !== 16'h0042) begin errors++; $display("FAIL pri_load_data got %h exp 0042", load_data); end
    sr_cs = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_acc();
    sr_address = 16'h3001; sr_cs = 4'b0001; mem_resp = 1'b0;
    step();
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_pre_read got %b exp 1", mem_read); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", mem_write); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
    checks++; if (load_data !== 16'h0000) begin errors++; $display("FAIL rst_load_data got %h exp 0000", load_data); end
    sr_cs = 4'b0000;
    #1;
    reset = 1'b0;
    step();
    #1;
    checks++; if (mem_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_idle got read %b stall %b exp 0 0", mem_read, stall); end
  endtask

  task automatic test_idle();
    sr_cs = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      mem_resp = i[0]; mem_rdata = 16'hCAFE;
      #1;
      checks++;
      if ({mem_read, mem_write, stall, done} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_cycle_%0d got rd %b wr %b stall %b done %b exp all 0", i, mem_read, mem_write, stall, done);
      end
      step();
    end
    mem_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sr_address = '0; sr_data = '0; sr_cs = '0; mem_resp = 1'b0; mem_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_load(16'h1235, 16'h1234, 16'hFF80);
    test_byte_load(16'h1234, 16'h1234, 16'hFFFF);
    test_byte_store();
    test_indirect_store();
    test_rd_priority();
    test_reset_mid_acc();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
